// File: rtl/cpu_exc_pkg.sv
// rtl/cpu_exc_pkg.sv - shared constants for the exception arbiter
package cpu_exc_pkg;

  // exc_req_i bit order; AdEL/TLBL are fetch faults when bad_addr_i equals the PC
  localparam int EXC_W       = 10;
  localparam int EXC_ADEL    = 0;
  localparam int EXC_TLBL    = 1;
  localparam int EXC_RI      = 2;
  localparam int EXC_CPU     = 3;
  localparam int EXC_SYSCALL = 4;
  localparam int EXC_WATCH   = 5;
  localparam int EXC_ADES    = 6;
  localparam int EXC_TLBS    = 7;
  localparam int EXC_MOD     = 8;
  localparam int EXC_ERET    = 9;

  localparam logic [4:0] EXCTYPE_NONE  = 5'h00;
  localparam logic [4:0] EXCTYPE_MOD   = 5'h01;
  localparam logic [4:0] EXCTYPE_TLBL  = 5'h02;
  localparam logic [4:0] EXCTYPE_TLBS  = 5'h03;
  localparam logic [4:0] EXCTYPE_ADEL  = 5'h04;
  localparam logic [4:0] EXCTYPE_ADES  = 5'h05;
  localparam logic [4:0] EXCTYPE_SYS   = 5'h08;
  localparam logic [4:0] EXCTYPE_RI    = 5'h0A;
  localparam logic [4:0] EXCTYPE_CPU   = 5'h0B;
  localparam logic [4:0] EXCTYPE_ERET  = 5'h0E;
  localparam logic [4:0] EXCTYPE_INT   = 5'h0F;
  localparam logic [4:0] EXCTYPE_WATCH = 5'h17;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EBASE  = 5'd15;

  // Cause bits software may write: IV, WP, IP1..IP0
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  typedef enum logic [1:0] {
    EXC_IDLE  = 2'd0,
    EXC_TAKE  = 2'd1,
    EXC_DRAIN = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority pick of one exception event
module exc_prio_enc
  import cpu_exc_pkg::*;
(
  input  logic [EXC_W-1:0] exc_req_i,
  input  logic             int_pending_i,
  input  logic             fetch_fault_i,
  output logic             hit_o,
  output logic [4:0]       code_o,
  output logic             fetch_o
);

  always_comb begin
    hit_o   = 1'b1;
    code_o  = EXCTYPE_NONE;
    fetch_o = 1'b0;
    if (int_pending_i) begin
      code_o = EXCTYPE_INT;
    end else if (fetch_fault_i && exc_req_i[EXC_ADEL]) begin
      code_o  = EXCTYPE_ADEL;
      fetch_o = 1'b1;
    end else if (fetch_fault_i && exc_req_i[EXC_TLBL]) begin
      code_o  = EXCTYPE_TLBL;
      fetch_o = 1'b1;
    end else if (exc_req_i[EXC_RI]) begin
      code_o = EXCTYPE_RI;
    end else if (exc_req_i[EXC_CPU]) begin
      code_o = EXCTYPE_CPU;
    end else if (exc_req_i[EXC_SYSCALL]) begin
      code_o = EXCTYPE_SYS;
    end else if (exc_req_i[EXC_WATCH]) begin
      code_o = EXCTYPE_WATCH;
    end else if (exc_req_i[EXC_ADEL]) begin
      code_o = EXCTYPE_ADEL;
    end else if (exc_req_i[EXC_ADES]) begin
      code_o = EXCTYPE_ADES;
    end else if (exc_req_i[EXC_TLBL]) begin
      code_o = EXCTYPE_TLBL;
    end else if (exc_req_i[EXC_TLBS]) begin
      code_o = EXCTYPE_TLBS;
    end else if (exc_req_i[EXC_MOD]) begin
      code_o = EXCTYPE_MOD;
    end else if (exc_req_i[EXC_ERET]) begin
      code_o = EXCTYPE_ERET;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// rtl/except_ctrl.sv - exception/interrupt arbiter feeding cp0_reg and the pipeline flush
module except_ctrl
  import cpu_exc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_GENERAL  = 32'h0000_0180,
  parameter logic [31:0] VEC_REFILL   = 32'h0000_0000,
  parameter logic [31:0] VEC_INT      = 32'h0000_0200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [31:0]       current_inst_addr_i,
  input  logic              is_in_delayslot_i,
  input  logic [EXC_W-1:0]  exc_req_i,
  input  logic              tlb_refill_i,
  input  logic [31:0]       bad_addr_i,
  input  logic              timer_int_i,
  input  logic [31:0]       cp0_status_i,
  input  logic [31:0]       cp0_cause_i,
  input  logic [31:0]       cp0_epc_i,
  input  logic [31:0]       cp0_ebase_i,
  input  logic              cp0_we_i,
  input  logic [4:0]        cp0_waddr_i,
  input  logic [31:0]       cp0_wdata_i,
  output logic              stall_o,
  output logic [31:0]       excepttype_o,
  output logic [31:0]       except_pc_o,
  output logic              except_ds_o,
  output logic [31:0]       bad_v_addr_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o
);

  localparam logic [2:0] DRAIN_LEN = 3'(FLUSH_CYCLES - 1);

  logic [31:0] status_eff, cause_eff, epc_eff, ebase_base;
  logic [7:0]  ip_masked;
  logic        int_pending, fetch_fault, hit, hit_fetch, take, is_tlb;
  logic [4:0]  code;
  logic [EXC_W-1:0] req_v;

  exc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] excepttype_q, excepttype_d;
  logic [31:0] except_pc_q, bad_v_addr_q, bad_v_addr_d, new_pc_q, new_pc_d;
  logic        except_ds_q;

  always_comb begin
    status_eff = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : cp0_status_i;
    epc_eff    = (cp0_we_i && cp0_waddr_i == CP0_EPC) ? cp0_wdata_i : cp0_epc_i;
    cause_eff  = cp0_cause_i;
    if (cp0_we_i && cp0_waddr_i == CP0_CAUSE) begin
      cause_eff = (cp0_cause_i & ~CAUSE_WMASK) | (cp0_wdata_i & CAUSE_WMASK);
    end
  end

  // Interrupts only attach to a real instruction so EPC is always precise
  assign ip_masked   = (cause_eff[15:8] | {timer_int_i, 7'b0}) & status_eff[15:8];
  assign int_pending = inst_valid_i && (|ip_masked) && status_eff[0] && !status_eff[1];
  assign req_v       = inst_valid_i ? exc_req_i : '0;
  assign fetch_fault = (bad_addr_i == current_inst_addr_i);
  assign ebase_base  = {cp0_ebase_i[31:12], 12'h000};

  exc_prio_enc u_prio (
    .exc_req_i     (req_v),
    .int_pending_i (int_pending),
    .fetch_fault_i (fetch_fault),
    .hit_o         (hit),
    .code_o        (code),
    .fetch_o       (hit_fetch)
  );

  assign is_tlb = (code == EXCTYPE_TLBL) || (code == EXCTYPE_TLBS);

  always_comb begin
    new_pc_d = ebase_base + VEC_GENERAL;
    if (code == EXCTYPE_ERET) begin
      new_pc_d = epc_eff;
    end else if (code == EXCTYPE_INT && cause_eff[23]) begin
      new_pc_d = ebase_base + VEC_INT;
    end else if (is_tlb && tlb_refill_i && !status_eff[1]) begin
      new_pc_d = ebase_base + VEC_REFILL;
    end
  end

  always_comb begin
    bad_v_addr_d = 32'h0;
    if (hit_fetch) begin
      bad_v_addr_d = current_inst_addr_i;
    end else if (code >= EXCTYPE_MOD && code <= EXCTYPE_ADES) begin
      bad_v_addr_d = bad_addr_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_o      = 1'b0;
    take         = 1'b0;
    excepttype_d = 32'h0;
    unique case (state_q)
      EXC_IDLE: begin
        if (hit) begin
          stall_o      = 1'b1;
          take         = 1'b1;
          excepttype_d = {27'b0, code};
          state_d      = EXC_TAKE;
        end
      end
      EXC_TAKE: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = EXC_DRAIN;
          cnt_d   = DRAIN_LEN;
        end else begin
          state_d = EXC_IDLE;
        end
      end
      EXC_DRAIN: begin
        if (cnt_q <= 3'd1) begin
          state_d = EXC_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = EXC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EXC_IDLE;
      cnt_q        <= 3'd0;
      excepttype_q <= 32'h0;
      except_pc_q  <= 32'h0;
      except_ds_q  <= 1'b0;
      bad_v_addr_q <= 32'h0;
      new_pc_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      excepttype_q <= excepttype_d;
      if (take) begin
        except_pc_q  <= current_inst_addr_i;
        except_ds_q  <= is_in_delayslot_i;
        bad_v_addr_q <= bad_v_addr_d;
        new_pc_q     <= new_pc_d;
      end
    end
  end

  assign excepttype_o = excepttype_q;
  assign except_pc_o  = except_pc_q;
  assign except_ds_o  = except_ds_q;
  assign bad_v_addr_o = bad_v_addr_q;
  assign new_pc_o     = new_pc_q;
  assign flush_o      = (state_q != EXC_IDLE);

  logic unused_bits;
  assign unused_bits = ^{cp0_ebase_i[11:0], status_eff[31:16], status_eff[7:2],
                         cause_eff[31:24], cause_eff[22:16], cause_eff[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// tb/tb_except_ctrl.sv - randomized self-checking bench for except_ctrl
module tb_except_ctrl;
  import cpu_exc_pkg::*;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid_i, is_in_delayslot_i, tlb_refill_i, timer_int_i, cp0_we_i;
  logic [31:0] current_inst_addr_i, bad_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic [31:0] cp0_ebase_i, cp0_wdata_i;
  logic [9:0]  exc_req_i;
  logic [4:0]  cp0_waddr_i;
  logic        stall_o, except_ds_o, flush_o;
  logic [31:0] excepttype_o, except_pc_o, bad_v_addr_o, new_pc_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] obs_type, obs_newpc, obs_badv;
  logic        obs_stall, obs_ds;
  logic [7:0]  prio_code [13] = '{8'h0F, 8'h04, 8'h02, 8'h0A, 8'h0B, 8'h08, 8'h17,
                                  8'h04, 8'h05, 8'h02, 8'h03, 8'h01, 8'h0E};

  except_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .exc_req_i(exc_req_i), .tlb_refill_i(tlb_refill_i), .bad_addr_i(bad_addr_i),
    .timer_int_i(timer_int_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .cp0_ebase_i(cp0_ebase_i), .cp0_we_i(cp0_we_i),
    .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i), .stall_o(stall_o),
    .excepttype_o(excepttype_o), .except_pc_o(except_pc_o), .except_ds_o(except_ds_o),
    .bad_v_addr_o(bad_v_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    inst_valid_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0; exc_req_i = 0;
    tlb_refill_i = 0; bad_addr_i = 0; timer_int_i = 0; cp0_status_i = 0; cp0_cause_i = 0;
    cp0_epc_i = 0; cp0_ebase_i = 32'h8000_0000; cp0_we_i = 0; cp0_waddr_i = 0; cp0_wdata_i = 0;
  endtask

  task automatic rand_inputs();
    inst_valid_i        = ($urandom_range(0, 9) < 8);
    current_inst_addr_i = {$urandom_range(0, 15), 12'h0, 14'($urandom), 2'b00};
    is_in_delayslot_i   = $urandom_range(0, 1);
    for (int b = 0; b < 10; b++) exc_req_i[b] = ($urandom_range(0, 11) == 0);
    tlb_refill_i        = $urandom_range(0, 1);
    bad_addr_i          = ($urandom_range(0, 2) == 0) ? current_inst_addr_i : $urandom;
    timer_int_i         = ($urandom_range(0, 4) == 0);
    cp0_status_i        = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
    cp0_cause_i         = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
    cp0_epc_i           = $urandom;
    cp0_ebase_i         = $urandom;
    cp0_we_i            = ($urandom_range(0, 3) == 0);
    cp0_waddr_i         = 5'($urandom_range(11, 15));
    cp0_wdata_i         = $urandom;
  endtask

  // Reference: scan the priority table and apply the vector/BadVAddr rules
  task automatic model(output int idx, output logic [31:0] typ, output logic [31:0] npc,
                       output logic [31:0] badv);
    logic [31:0] st, ca, ep, base;
    logic        v, fetch, intp;
    logic        hitv [13];
    st = (cp0_we_i && cp0_waddr_i == 12) ? cp0_wdata_i : cp0_status_i;
    ep = (cp0_we_i && cp0_waddr_i == 14) ? cp0_wdata_i : cp0_epc_i;
    ca = cp0_cause_i;
    if (cp0_we_i && cp0_waddr_i == 13) begin
      ca[9:8] = cp0_wdata_i[9:8]; ca[23] = cp0_wdata_i[23]; ca[22] = cp0_wdata_i[22];
    end
    v     = inst_valid_i;
    fetch = (bad_addr_i == current_inst_addr_i);
    intp  = v && (((ca[15:8] | {timer_int_i, 7'b0}) & st[15:8]) != 0) && st[0] && !st[1];
    hitv[0]  = intp;
    hitv[1]  = v && exc_req_i[EXC_ADEL] && fetch;
    hitv[2]  = v && exc_req_i[EXC_TLBL] && fetch;
    hitv[3]  = v && exc_req_i[EXC_RI];
    hitv[4]  = v && exc_req_i[EXC_CPU];
    hitv[5]  = v && exc_req_i[EXC_SYSCALL];
    hitv[6]  = v && exc_req_i[EXC_WATCH];
    hitv[7]  = v && exc_req_i[EXC_ADEL] && !fetch;
    hitv[8]  = v && exc_req_i[EXC_ADES];
    hitv[9]  = v && exc_req_i[EXC_TLBL] && !fetch;
    hitv[10] = v && exc_req_i[EXC_TLBS];
    hitv[11] = v && exc_req_i[EXC_MOD];
    hitv[12] = v && exc_req_i[EXC_ERET];
    idx = -1;
    for (int i = 0; i < 13; i++) if (hitv[i] && idx < 0) idx = i;
    typ  = (idx < 0) ? 32'h0 : {24'h0, prio_code[idx]};
    base = cp0_ebase_i & 32'hFFFF_F000;
    if (idx == 12)                                         npc = ep;
    else if (idx == 0 && ca[23])                           npc = base + 32'h200;
    else if ((idx == 2 || idx == 9 || idx == 10) && tlb_refill_i && !st[1]) npc = base;
    else                                                   npc = base + 32'h180;
    if (idx == 1 || idx == 2)          badv = current_inst_addr_i;
    else if (typ >= 1 && typ <= 5)     badv = bad_addr_i;
    else                               badv = 32'h0;
  endtask

  // Called at a negedge with inputs already applied; returns at a negedge in IDLE
  task automatic run_vec();
    int          idx;
    logic [31:0] e_type, e_npc, e_badv, e_pc;
    logic        e_ds;
    model(idx, e_type, e_npc, e_badv);
    e_pc = current_inst_addr_i;
    e_ds = is_in_delayslot_i;
    #1;
    obs_stall = stall_o;
    check("stall", {31'b0, stall_o}, {31'b0, idx >= 0});
    @(negedge clk);
    obs_type = excepttype_o; obs_newpc = new_pc_o; obs_badv = bad_v_addr_o; obs_ds = except_ds_o;
    if (idx >= 0) begin
      check("excepttype", excepttype_o, e_type);
      check("except_pc", except_pc_o, e_pc);
      check("except_ds", {31'b0, except_ds_o}, {31'b0, e_ds});
      check("bad_v_addr", bad_v_addr_o, e_badv);
      check("new_pc", new_pc_o, e_npc);
      check("flush_take", {31'b0, flush_o}, 32'h1);
      for (int k = 1; k < FLUSH; k++) begin
        rand_inputs();
        inst_valid_i = 1; exc_req_i[EXC_SYSCALL] = 1;
        @(negedge clk);
        #1;
        check("flush_drain", {31'b0, flush_o}, 32'h1);
        check("type_drain", excepttype_o, 32'h0);
        check("stall_drain", {31'b0, stall_o}, 32'h0);
        check("newpc_hold", new_pc_o, e_npc);
      end
      @(negedge clk);
      check("flush_end", {31'b0, flush_o}, 32'h0);
    end else begin
      check("type_none", excepttype_o, 32'h0);
      check("flush_none", {31'b0, flush_o}, 32'h0);
    end
  endtask

  initial begin
    quiet();
    #1;
    check("rst_type", excepttype_o, 32'h0);
    check("rst_flush", {31'b0, flush_o}, 32'h0);
    check("rst_newpc", new_pc_o, 32'h0);
    check("rst_badv", bad_v_addr_o, 32'h0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // Syscall, general vector
    quiet(); inst_valid_i = 1; current_inst_addr_i = 32'h8000_1000;
    exc_req_i[EXC_SYSCALL] = 1;
    run_vec();
    check("sys_type", obs_type, 32'h08);
    check("sys_newpc", obs_newpc, 32'h8000_0180);

    // Interrupt in delay slot, IV=0 then IV=1
    for (int iv = 0; iv < 2; iv++) begin
      quiet(); inst_valid_i = 1; current_inst_addr_i = 32'h8000_0204; is_in_delayslot_i = 1;
      cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400 | (iv == 1 ? 32'h0080_0000 : 0);
      run_vec();
      check("int_type", obs_type, 32'h0F);
      check("int_ds", {31'b0, obs_ds}, 32'h1);
      check("int_newpc", obs_newpc, iv == 1 ? 32'h8000_0200 : 32'h8000_0180);
    end

    // Forwarded Status=0, then EXL=1: no interrupt
    quiet(); inst_valid_i = 1; cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400;
    cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0;
    run_vec();
    check("fwd_status_nostall", {31'b0, obs_stall}, 32'h0);
    quiet(); inst_valid_i = 1; cp0_status_i = 32'h0000_FF03; cp0_cause_i = 32'h0000_0400;
    run_vec();
    check("exl_nostall", {31'b0, obs_stall}, 32'h0);

    // RI beats AdES
    quiet(); inst_valid_i = 1; current_inst_addr_i = 32'h8000_3000; bad_addr_i = 32'h3;
    exc_req_i[EXC_RI] = 1; exc_req_i[EXC_ADES] = 1;
    run_vec();
    check("ri_type", obs_type, 32'h0A);
    check("ri_badv", obs_badv, 32'h0);

    // eret with forwarded EPC
    quiet(); inst_valid_i = 1; current_inst_addr_i = 32'h8000_4000; exc_req_i[EXC_ERET] = 1;
    cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h8000_2000;
    run_vec();
    check("eret_newpc", obs_newpc, 32'h8000_2000);

    // TLBL refill with EXL=1 goes to the general vector
    quiet(); inst_valid_i = 1; current_inst_addr_i = 32'h8000_5000; bad_addr_i = 32'h0040_0000;
    exc_req_i[EXC_TLBL] = 1; tlb_refill_i = 1; cp0_status_i = 32'h2;
    run_vec();
    check("tlbl_exl_newpc", obs_newpc, 32'h8000_0180);

    for (int t = 0; t < 300; t++) begin
      rand_inputs();
      run_vec();
    end

    // TLBL refill with EXL=0, then reset during DRAIN
    quiet(); inst_valid_i = 1; current_inst_addr_i = 32'h8000_6000; bad_addr_i = 32'h0040_0000;
    exc_req_i[EXC_TLBL] = 1; tlb_refill_i = 1;
    #1;
    check("tlb_stall", {31'b0, stall_o}, 32'h1);
    @(negedge clk);
    check("tlb_refill_newpc", new_pc_o, 32'h8000_0000);
    check("tlb_type", excepttype_o, 32'h02);
    quiet();
    @(negedge clk);
    check("drain_flush", {31'b0, flush_o}, 32'h1);
    #2 rst = 0;
    #1;
    check("rst_mid_flush", {31'b0, flush_o}, 32'h0);
    check("rst_mid_newpc", new_pc_o, 32'h0);
    @(negedge clk);
    rst = 1;
    quiet(); inst_valid_i = 1; exc_req_i[EXC_SYSCALL] = 1;
    #1;
    check("idle_after_rst", {31'b0, stall_o}, 32'h1);
    @(negedge clk);
    check("post_rst_type", excepttype_o, 32'h08);
    quiet();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception/interrupt arbiter that drives the CP0 register block's exception inputs.
- Samples per-instruction exception requests from the MEM stage and pending interrupts (Status/Cause, with in-flight CP0 writes forwarded). Picks one event by fixed priority.
- Produces the registered excepttype/EPC-source/BadVAddr pulse that CP0 consumes, the pipeline flush, and the redirect PC.
- Sits between the mem stage, cp0_reg and ctrl/pc_reg.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays high per taken event (range 1..7).
- VEC_GENERAL, 32'h00000180, general exception offset from EBase.
- VEC_REFILL, 32'h00000000, TLB-refill offset from EBase.
- VEC_INT, 32'h00000200, interrupt offset when Cause.IV=1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- inst_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
- current_inst_addr_i  in  32  PC of the MEM-stage instruction
- is_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- exc_req_i  in  10  per-instruction requests; bit order from package EXC_* constants
- tlb_refill_i  in  1  TLBL/TLBS is a refill miss (no matching entry)
- bad_addr_i  in  32  faulting virtual address for AdEL/AdES/TLB requests
- timer_int_i  in  1  timer interrupt from cp0_reg, ORed into IP7
- cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i  in  32 each  current CP0 values
- cp0_we_i  in  1, cp0_waddr_i  in  5, cp0_wdata_i  in  32  in-flight mtc0 (MEM/WB) for forwarding
- stall_o  out  1  combinational; holds pipeline in the detection cycle
- excepttype_o  out  32  registered one-cycle code to cp0_reg
- except_pc_o  out  32  registered; PC for CP0 EPC logic
- except_ds_o  out  1  registered delay-slot flag
- bad_v_addr_o  out  32  registered BadVAddr
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE, drain counter=0.
  - All registered outputs are 0, including excepttype_o=32'h0 and flush_o=0.
  - Reset mid-FLUSH aborts the flush immediately.
- Forwarding: effective Status/EPC = cp0_wdata_i when cp0_we_i and waddr matches (12/14), else the input. Effective Cause merges only bits 9:8, 23 and 22 from wdata when waddr=13.
- Interrupt pending: |((Cause[15:8] | {timer_int_i,7'b0}) & Status[15:8]) && Status[0] && !Status[1]. Only considered when inst_valid_i=1, so EPC is always precise.
- Priority, highest first, with the excepttype code sent to CP0:
  1. interrupt 0x0F
  2. fetch AdEL 0x04
  3. fetch TLBL 0x02
  4. RI 0x0A
  5. CpU 0x0B
  6. Syscall 0x08
  7. Watch 0x17
  8. data AdEL 0x04
  9. AdES 0x05
  10. data TLBL 0x02
  11. TLBS 0x03
  12. Mod 0x01
  13. eret 0x0E
- Requests with inst_valid_i=0 are ignored.
- FSM:
  - IDLE:
    - A hit in cycle N sets stall_o=1 combinationally in cycle N.
    - At edge N, register the code, PC, delay-slot flag and bad_addr, and go to TAKE.
  - TAKE (cycle N+1):
    - excepttype_o is valid for exactly this cycle; flush_o=1; new_pc_o valid.
    - Next state is DRAIN if FLUSH_CYCLES>1, else IDLE.
  - DRAIN:
    - excepttype_o=0, flush_o=1, new_pc_o held.
    - Inputs are ignored and stall_o=0.
    - Count FLUSH_CYCLES-1 cycles, then go to IDLE.
- new_pc_o, computed from Status/Cause/EBase captured at detection:
  - eret: effective EPC (forwarded).
  - interrupt with Cause.IV=1: {EBase[31:12],12'h0}+VEC_INT.
  - TLBL/TLBS with tlb_refill_i=1 and EXL=0: +VEC_REFILL.
  - all other events: +VEC_GENERAL.
- bad_v_addr_o: bad_addr_i for codes 0x01–0x05; fetch AdEL/TLBL use current_inst_addr_i; otherwise 0.
- eret with EXL=0: still taken and redirects to EPC.
- Simultaneous requests: only the highest priority is taken; the others are discarded (the flush kills the instruction).

Decomposition:
- Package cpu_exc_pkg holds:
  - EXC_* bit indices for exc_req_i;
  - excepttype codes (EXCTYPE_INT … EXCTYPE_ERET);
  - CP0 register addresses 12/13/14/15;
  - FSM state encoding.
- Sub-module exc_prio_enc: combinational priority encoder from exc_req_i and int_pending to code plus hit.

Test Plan:
- Syscall at PC 0x80001000, not in delay slot, EBase 0x80000000 → stall_o=1 in cycle N; cycle N+1 excepttype_o=0x08, except_pc_o=0x80001000, new_pc_o=0x80000180; flush_o high for 2 cycles.
- Status=0x0000FF01, cause IP2 set, valid instruction in delay slot at 0x80000204 → excepttype_o=0x0F, except_ds_o=1, new_pc_o=0x80000180 (IV=0) / 0x80000200 (IV=1).
- Same cycle: mtc0 Status=0x00000000 in flight plus pending IP2 → no exception; same with EXL=1 → none.
- RI and data AdES at once, bad_addr 0x00000003 → only 0x0A taken, bad_v_addr_o=0.
- eret with forwarded mtc0 EPC=0x80002000 while cp0_epc_i=0x0 → new_pc_o=0x80002000.
- TLBL refill with EXL=0 → new_pc_o=EBase+0x000; with EXL=1 → EBase+0x180. Then rst low during DRAIN → flush_o=0 immediately and FSM=IDLE.
